// File: rtl/color_sensor_emulator.sv
// Emulates a light-to-frequency colour sensor: scaled square wave per selected photodiode.
// Optional COLOR_SENSOR_EMU_EDGE_CNT_EN adds a saturating rising-edge counter on freq.
`timescale 1ns/1ps
module color_sensor_emulator #(
  parameter int unsigned SETTLE_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  scale,
  input  logic [1:0]  filter,
  input  logic        enf,
  input  logic [7:0]  red_level,
  input  logic [7:0]  blue_level,
  input  logic [7:0]  clear_level,
  input  logic [7:0]  green_level,
  output logic        freq,
`ifdef COLOR_SENSOR_EMU_EDGE_CNT_EN
  output logic [15:0] edge_count,
`endif
  output logic [1:0]  state
);

  typedef enum logic [1:0] {
    ST_PDOWN  = 2'b00,
    ST_SETTLE = 2'b01,
    ST_RUN    = 2'b10
  } state_t;

  localparam logic [7:0] SETTLE_LAST = 8'(SETTLE_CYCLES - 1);

  state_t      state_q, state_d;
  logic [7:0]  settle_q, settle_d;
  logic [13:0] hp_q, hp_d;
  logic        wave_q, wave_d;
  logic        freq_q, freq_d;
  logic [1:0]  prev_scale_q;
  logic [1:0]  prev_filter_q;

  logic [7:0]  level_s;
  logic [5:0]  mult_s;
  logic [13:0] half_s;
  logic [13:0] half_last_s;
  logic        change_s;
  logic        pdown_s;

  // Channel and scaling selection feeding the half-period.
  always_comb begin
    level_s = 8'd0;
    case (filter)
      2'b00:   level_s = red_level;
      2'b01:   level_s = blue_level;
      2'b10:   level_s = clear_level;
      2'b11:   level_s = green_level;
      default: level_s = 8'd0;
    endcase
    mult_s = 6'd0;
    case (scale)
      2'b01:   mult_s = 6'd50;
      2'b10:   mult_s = 6'd5;
      2'b11:   mult_s = 6'd1;
      default: mult_s = 6'd0;
    endcase
  end

  assign half_s      = {6'd0, level_s} * {8'd0, mult_s};
  assign half_last_s = half_s - 14'd1;
  assign pdown_s     = (scale == 2'b00);
  assign change_s    = (scale != prev_scale_q) || (filter != prev_filter_q);

  // State and datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= ST_PDOWN;
      settle_q      <= 8'd0;
      hp_q          <= 14'd0;
      wave_q        <= 1'b0;
      freq_q        <= 1'b0;
      prev_scale_q  <= 2'b00;
      prev_filter_q <= 2'b00;
    end else begin
      state_q       <= state_d;
      settle_q      <= settle_d;
      hp_q          <= hp_d;
      wave_q        <= wave_d;
      freq_q        <= freq_d;
      prev_scale_q  <= scale;
      prev_filter_q <= filter;
    end
  end

  // Next-state logic; power-down wins over any pending change.
  always_comb begin
    state_d = state_q;
    if (pdown_s) begin
      state_d = ST_PDOWN;
    end else begin
      case (state_q)
        ST_PDOWN: state_d = ST_SETTLE;
        ST_SETTLE: begin
          if (change_s) begin
            state_d = ST_SETTLE;
          end else if (settle_q == SETTLE_LAST) begin
            state_d = ST_RUN;
          end else begin
            state_d = ST_SETTLE;
          end
        end
        ST_RUN: begin
          if (change_s) begin
            state_d = ST_SETTLE;
          end else begin
            state_d = ST_RUN;
          end
        end
        default: state_d = ST_PDOWN;
      endcase
    end
  end

  // Settle counter, half-period counter and internal wave.
  always_comb begin
    settle_d = settle_q;
    hp_d     = hp_q;
    wave_d   = wave_q;
    if (pdown_s) begin
      settle_d = 8'd0;
      hp_d     = 14'd0;
      wave_d   = 1'b0;
    end else begin
      case (state_q)
        ST_SETTLE: begin
          hp_d   = 14'd0;
          wave_d = 1'b0;
          if (change_s || (settle_q == SETTLE_LAST)) begin
            settle_d = 8'd0;
          end else begin
            settle_d = settle_q + 8'd1;
          end
        end
        ST_RUN: begin
          settle_d = 8'd0;
          if (change_s || (level_s == 8'd0)) begin
            hp_d   = 14'd0;
            wave_d = 1'b0;
          end else if (hp_q >= half_last_s) begin
            // Shrinking H below the current count wraps on the very next edge.
            hp_d   = 14'd0;
            wave_d = ~wave_q;
          end else begin
            hp_d   = hp_q + 14'd1;
            wave_d = wave_q;
          end
        end
        default: begin
          settle_d = 8'd0;
          hp_d     = 14'd0;
          wave_d   = 1'b0;
        end
      endcase
    end
  end

  // Output gating; enable masks the pin only, counters keep running.
  always_comb begin
    freq_d = wave_q & enf;
  end

  assign freq  = freq_q;
  assign state = state_q;

`ifdef COLOR_SENSOR_EMU_EDGE_CNT_EN
  logic [15:0] edge_q, edge_d;

  // Rising edges counted as they appear on the registered pin.
  always_comb begin
    edge_d = edge_q;
    if (state_d != ST_RUN) begin
      edge_d = 16'd0;
    end else if (freq_d && !freq_q && (edge_q != 16'hFFFF)) begin
      edge_d = edge_q + 16'd1;
    end else begin
      edge_d = edge_q;
    end
  end

  // Edge counter register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      edge_q <= 16'd0;
    end else begin
      edge_q <= edge_d;
    end
  end

  assign edge_count = edge_q;
`endif

endmodule

// File: doc/color_sensor_emulator.md
COLOR_SENSOR_EMULATOR -- requirements
Module: color_sensor_emulator

Interface
REQ-001 Parameter SETTLE_CYCLES, default 16: clk cycles freq is held low after any scale or filter change; legal range 1..255.
REQ-002 clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 rst  input  1  reset, asynchronous and active-high.
REQ-004 scale  input  2  frequency scaling select: 00 power-down, 01 2 %, 10 20 %, 11 100 %.
REQ-005 filter  input  2  photodiode select: 00 red, 01 blue, 10 clear, 11 green.
REQ-006 enf  input  1  output enable, active-high; when 0, freq is driven 0.
REQ-007 red_level, blue_level, clear_level, green_level  input  8 each  base half-period, in clk cycles, of each channel at 100 % scaling.
REQ-008 freq  output  1  emulated sensor square-wave output.
REQ-009 state  output  2  current FSM state: 00 PDOWN, 01 SETTLE, 10 RUN.

Function
REQ-010 Selected level L is the level input chosen by filter, sampled every cycle.
REQ-011 Scale multiplier M is 1 for 11, 5 for 10, and 50 for 01.
REQ-012 Half-period H = L × M, computed in at least 14 bits without truncation (max 255 × 50 = 12750).
REQ-013 FSM states: PDOWN, SETTLE, RUN.
REQ-014 PDOWN: entered whenever scale = 00, from any state, on the next clk edge; counter and internal wave cleared; freq = 0.
REQ-015 PDOWN -> SETTLE when scale ≠ 00.
REQ-016 SETTLE: settle counter counts 0..SETTLE_CYCLES-1; internal wave held 0.
REQ-017 SETTLE -> RUN on the cycle the settle counter reaches SETTLE_CYCLES-1; the half-period counter starts at 0 with the internal wave low.
REQ-018 RUN: the half-period counter increments each cycle; when it equals H-1, it wraps to 0 and the internal wave toggles, so each level lasts exactly H cycles.
REQ-019 A change of scale (non-00) or filter, detected against the registered previous value, forces SETTLE from SETTLE or RUN and restarts the settle count at 0.
REQ-020 A change and scale = 00 in the same cycle: PDOWN takes priority.
REQ-021 In RUN with L = 0: the internal wave is held 0 and the counter held 0; when L becomes nonzero, counting restarts from 0 with the wave low.
REQ-022 A level-input change without a filter change: no SETTLE; the new H applies from the next wrap; if the counter is already ≥ new H-1, it wraps at the next cycle.
REQ-023 freq = internal wave AND enf, registered, adding 1 cycle of latency; enf does not stop the counters.
REQ-024 state output reflects the registered FSM state with no extra latency.

Reset
REQ-025 Asserting rst immediately forces state = PDOWN, freq = 0, all counters = 0, the internal wave = 0, and the previous scale/filter registers = 00.
REQ-026 After rst deasserts with scale ≠ 00, the FSM enters SETTLE on the first clk edge.
REQ-027 rst asserted mid-RUN or mid-SETTLE discards all progress; no partial pulse completes.

Configuration
REQ-028 Macro COLOR_SENSOR_EMU_EDGE_CNT_EN; when defined, adds output edge_count (16 bits).
REQ-029 edge_count counts rising edges of the registered freq and saturates at 16'hFFFF.
REQ-030 edge_count clears to 0 on rst and on every entry to SETTLE or PDOWN.
REQ-031 Without COLOR_SENSOR_EMU_EDGE_CNT_EN, the edge_count port and its logic are absent; all other behaviour is identical.

Verification
REQ-032 Reset then scale=11, filter=00, red_level=4, enf=1 -> 16 cycles SETTLE, then freq toggles every 4 cycles (period 8), first rising edge 4+1 cycles after RUN entry.
REQ-033 RUN with scale=11, green_level=3; switch scale to 10 -> freq low 16 cycles, then half-period 15 cycles.
REQ-034 RUN with filter=01, blue_level=10; switch filter to 10, clear_level=2 -> SETTLE 16 cycles, then half-period 2; simultaneously set scale=00 -> PDOWN, freq=0.
REQ-035 RUN with enf=0 for 20 cycles, then enf=1 -> freq stays 0 while disabled, then resumes mid-phase consistent with an uninterrupted counter.
REQ-036 scale=01, red_level=255 -> half-period 12750 cycles exactly; red_level=0 -> freq constant 0.
REQ-037 With COLOR_SENSOR_EMU_EDGE_CNT_EN: scale=11, red_level=1 for 200 RUN cycles -> edge_count = 100 (±1); filter change -> edge_count = 0 next cycle; rst mid-RUN -> all outputs zero immediately.
